// File: rtl/inst_scheduler.sv
// rtl/inst_scheduler.sv - instruction FIFO and issue sequencer for the systolic array
module inst_scheduler #(
    parameter int                    INST_BITS      = 68,
    parameter int                    OPCODE_FROM    = 67,
    parameter int                    OPCODE_TO      = 64,
    parameter logic [INST_BITS-1:0]  IDLE_INST      = {INST_BITS{1'b0}},
    parameter int                    QUEUE_DEPTH    = 8,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    // clock and synchronous active-high reset
    input  logic                           clk,
    input  logic                           reset,
    // enqueue side
    input  logic [INST_BITS-1:0]           s_inst,
    input  logic                           s_inst_valid,
    output logic                           s_inst_ready,
    // array side
    input  logic                           run,
    input  logic                           idle_flag,
    input  logic                           flag,
    output logic [INST_BITS-1:0]           instruction,
    // status
    output logic                           busy,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic [15:0]                    issued_count,
    output logic                           last_flag,
    output logic                           done,
    output logic                           error
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OP_W  = OPCODE_FROM - OPCODE_TO + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [OP_W-1:0]  NOP_OPCODE = IDLE_INST[OPCODE_FROM:OPCODE_TO];
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH      = CNT_W'(QUEUE_DEPTH);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_ERROR     = 2'd3;

    logic [1:0]           state;
    logic [INST_BITS-1:0] mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [TMR_W-1:0]     timer;
    logic [INST_BITS-1:0] head;
    logic                 push;
    logic                 pop;
    logic                 head_is_nop;

    // Ready looks only at the registered count, so a full queue refuses a
    // push even in a cycle where the head is popped.
    assign s_inst_ready = count < DEPTH;
    assign push         = s_inst_valid & s_inst_ready;
    assign head         = mem[rd_ptr];
    assign head_is_nop  = head[OPCODE_FROM:OPCODE_TO] == NOP_OPCODE;
    // Both issue and no-op discard consume the head; at most one per cycle.
    assign pop          = (state == S_IDLE) && run && (count != '0) && idle_flag && !error;
    assign busy         = state != S_IDLE;
    assign queue_count  = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            instruction  <= IDLE_INST;
            timer        <= '0;
            issued_count <= '0;
            last_flag    <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop && !head_is_nop) begin
                        instruction <= head;
                        timer       <= '0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!idle_flag) begin
                        instruction <= IDLE_INST;
                        state       <= S_WAIT_DONE;
                    end else if (timer == TMR_LAST) begin
                        instruction <= IDLE_INST;
                        error       <= 1'b1;
                        state       <= S_ERROR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (idle_flag) begin
                        issued_count <= issued_count + 16'd1;
                        last_flag    <= flag;
                        // A push landing on the completion edge means more work
                        // is coming, so the batch is not finished yet.
                        done         <= (count == '0) && !push;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    instruction <= IDLE_INST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_scheduler.sv
// tb/tb_inst_scheduler.sv - self-checking bench for inst_scheduler
module tb_inst_scheduler;

    localparam int IB    = 68;
    localparam int DEPTH = 8;
    localparam int TMO   = 1024;
    localparam logic [IB-1:0] IDLE = '0;

    typedef struct {
        logic          rst;
        logic          vld;
        logic [IB-1:0] data;
        logic          idl;
        logic          flg;
        logic [IB-1:0] e_inst;
        int            e_qc;
        logic          e_busy;
        logic          e_done;
        logic          e_rdy;
        logic          e_lf;
        int            e_ic;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [IB-1:0] s_inst;
    logic          s_inst_valid;
    logic          s_inst_ready;
    logic          run;
    logic          idle_flag;
    logic          flag;
    logic [IB-1:0] instruction;
    logic          busy;
    logic [3:0]    queue_count;
    logic [15:0]   issued_count;
    logic          last_flag;
    logic          done;
    logic          error;

    inst_scheduler #(
        .INST_BITS(IB), .OPCODE_FROM(67), .OPCODE_TO(64), .IDLE_INST(IDLE),
        .QUEUE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .s_inst(s_inst), .s_inst_valid(s_inst_valid), .s_inst_ready(s_inst_ready),
        .run(run), .idle_flag(idle_flag), .flag(flag), .instruction(instruction),
        .busy(busy), .queue_count(queue_count), .issued_count(issued_count),
        .last_flag(last_flag), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [IB-1:0] issues[$];
    logic [IB-1:0] expq[$];
    logic [IB-1:0] prev_inst = '0;
    logic          auto_ack  = 1'b0;
    logic          exp_lf    = 1'b0;
    int            am_phase  = 0;
    int            am_cnt    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IB-1:0] mk_op(input int i);
        return {4'(i % 15 + 1), 32'hF00D_0000, 32'(i)};
    endfunction

    function automatic logic [IB-1:0] rand_inst();
        logic [3:0] op;
        op = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        return {op, 32'($urandom), 32'($urandom)};
    endfunction

    // One clock: sample after the edge, record new issues, and run the array
    // model (acknowledge after a random delay, stay busy a random time).
    task automatic tick();
        @(posedge clk);
        #1;
        if (instruction !== IDLE && prev_inst === IDLE) issues.push_back(instruction);
        prev_inst = instruction;
        if (auto_ack) begin
            if (am_phase == 0 && instruction !== IDLE) begin
                am_cnt   = $urandom_range(0, 3);
                am_phase = 1;
            end
            if (am_phase == 1) begin
                if (am_cnt == 0) begin
                    idle_flag = 1'b0;
                    am_cnt    = $urandom_range(1, 4);
                    am_phase  = 2;
                end else begin
                    am_cnt--;
                end
            end else if (am_phase == 2) begin
                am_cnt--;
                if (am_cnt == 0) begin
                    idle_flag = 1'b1;
                    flag      = 1'($urandom_range(0, 1));
                    exp_lf    = flag;
                    am_phase  = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        auto_ack     = 1'b0;
        reset        = 1'b1;
        s_inst_valid = 1'b0;
        idle_flag    = 1'b1;
        flag         = 1'b0;
        run          = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vec_t          tbl[18];
        logic [IB-1:0] op_a;
        logic [IB-1:0] op_b;
        int            lim;
        logic          drained;

        reset = 1'b1; s_inst = '0; s_inst_valid = 1'b0; run = 1'b1; idle_flag = 1'b1; flag = 1'b0;
        op_a = 68'h1_0000_0000_0000_0ABC;

        // Single issue: ack dropped 3 cycles after issue, raised 10 cycles later.
        for (int i = 0; i < 18; i++) begin
            tbl[i] = '{rst: 1'b0, vld: 1'b0, data: '0, idl: 1'b1, flg: 1'b0, e_inst: '0, e_qc: 0,
                       e_busy: 1'b0, e_done: 1'b0, e_rdy: 1'b1, e_lf: 1'b0, e_ic: 0};
        end
        tbl[0].rst = 1'b1;
        tbl[1].vld = 1'b1; tbl[1].data = op_a; tbl[1].e_qc = 1;
        for (int i = 2; i <= 5; i++) begin tbl[i].e_inst = op_a; tbl[i].e_busy = 1'b1; end
        for (int i = 6; i <= 15; i++) begin tbl[i].idl = 1'b0; tbl[i].e_busy = 1'b1; end
        tbl[16].flg = 1'b1; tbl[16].e_ic = 1; tbl[16].e_lf = 1'b1; tbl[16].e_done = 1'b1;
        tbl[17].flg = 1'b1; tbl[17].e_ic = 1; tbl[17].e_lf = 1'b1;

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst; s_inst_valid = tbl[i].vld; s_inst = tbl[i].data;
            idle_flag = tbl[i].idl; flag = tbl[i].flg;
            tick();
            check($sformatf("tbl%0d.instruction", i), instruction, tbl[i].e_inst);
            check($sformatf("tbl%0d.queue_count", i), queue_count, tbl[i].e_qc);
            check($sformatf("tbl%0d.busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d.done", i), done, tbl[i].e_done);
            check($sformatf("tbl%0d.ready", i), s_inst_ready, tbl[i].e_rdy);
            check($sformatf("tbl%0d.last_flag", i), last_flag, tbl[i].e_lf);
            check($sformatf("tbl%0d.issued_count", i), issued_count, tbl[i].e_ic);
            check($sformatf("tbl%0d.error", i), error, 1'b0);
        end

        // Fill to full with the array busy, then release and check order.
        do_reset();
        idle_flag = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s_inst_valid = 1'b1; s_inst = mk_op(i);
            tick();
            check($sformatf("fill%0d.queue_count", i), queue_count, (i < 8) ? i + 1 : 8);
            check($sformatf("fill%0d.ready", i), s_inst_ready, (i + 1 < 8) ? 1 : 0);
        end
        s_inst_valid = 1'b0;
        issues.delete();
        prev_inst = instruction;
        am_phase  = 0;
        idle_flag = 1'b1;
        auto_ack  = 1'b1;
        lim = 0;
        while (issued_count != 16'd8 && lim < 500) begin tick(); lim++; end
        check("fill.issued_count", issued_count, 16'd8);
        check("fill.issue_total", issues.size(), 8);
        for (int i = 0; i < 8 && i < issues.size(); i++)
            check($sformatf("fill.order%0d", i), issues[i], mk_op(i));

        // No-op discard between two real ops.
        do_reset();
        op_b = 68'h2_0000_0000_0000_0B0B;
        run = 1'b0;
        s_inst_valid = 1'b1;
        s_inst = op_a; tick();
        s_inst = IDLE; tick(); tick();
        s_inst = op_b; tick();
        s_inst_valid = 1'b0;
        check("nop.queued", queue_count, 4);
        issues.delete(); prev_inst = instruction;
        run = 1'b1; tick();
        check("nop.issue_a", instruction, op_a);
        check("nop.count_a", queue_count, 3);
        idle_flag = 1'b0; tick();
        check("nop.ack_a", instruction, IDLE);
        idle_flag = 1'b1; tick();
        check("nop.done_a_count", issued_count, 1);
        check("nop.done_a_busy", busy, 1'b0);
        check("nop.done_a_pulse", done, 1'b0);
        tick();
        check("nop.discard1_count", queue_count, 2);
        check("nop.discard1_inst", instruction, IDLE);
        tick();
        check("nop.discard2_count", queue_count, 1);
        check("nop.discard2_inst", instruction, IDLE);
        tick();
        check("nop.issue_b", instruction, op_b);
        check("nop.count_b", queue_count, 0);
        idle_flag = 1'b0; tick();
        idle_flag = 1'b1; flag = 1'b1; tick();
        check("nop.issued_count", issued_count, 2);
        check("nop.done_pulse", done, 1'b1);
        check("nop.last_flag", last_flag, 1'b1);
        tick();
        check("nop.done_drop", done, 1'b0);
        check("nop.issue_total", issues.size(), 2);

        // Timeout: idle_flag never drops.
        do_reset();
        s_inst_valid = 1'b1; s_inst = mk_op(40); tick();
        s_inst = mk_op(41); tick();
        s_inst_valid = 1'b0;
        check("tmo.issue", instruction, mk_op(40));
        check("tmo.count", queue_count, 1);
        repeat (TMO - 1) tick();
        check("tmo.before_error", error, 1'b0);
        check("tmo.before_inst", instruction, mk_op(40));
        tick();
        check("tmo.error", error, 1'b1);
        check("tmo.inst_idle", instruction, IDLE);
        check("tmo.busy", busy, 1'b1);
        s_inst_valid = 1'b1; s_inst = mk_op(42); tick();
        s_inst_valid = 1'b0;
        check("tmo.push_in_error", queue_count, 2);
        repeat (20) tick();
        check("tmo.no_issue", instruction, IDLE);
        check("tmo.held_count", queue_count, 2);
        check("tmo.sticky", error, 1'b1);

        // Halt during wait, then reset with the queue loaded.
        do_reset();
        s_inst_valid = 1'b1; s_inst = mk_op(20); tick();
        s_inst = mk_op(21); tick();
        s_inst = mk_op(22); tick();
        s_inst_valid = 1'b0;
        check("halt.inst", instruction, mk_op(20));
        check("halt.count", queue_count, 2);
        idle_flag = 1'b0; tick();
        run = 1'b0;
        repeat (3) tick();
        check("halt.still_busy", busy, 1'b1);
        idle_flag = 1'b1; tick();
        check("halt.completed", issued_count, 1);
        check("halt.idle", busy, 1'b0);
        repeat (3) tick();
        check("halt.no_issue", instruction, IDLE);
        check("halt.retained", queue_count, 2);
        s_inst_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin s_inst = mk_op(23 + k); tick(); end
        s_inst_valid = 1'b0;
        check("halt.loaded", queue_count, 6);
        run = 1'b1; tick();
        check("halt.resume", instruction, mk_op(21));
        check("halt.five_left", queue_count, 5);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst.count", queue_count, 0);
        check("rst.busy", busy, 1'b0);
        check("rst.inst", instruction, IDLE);
        check("rst.ready", s_inst_ready, 1'b1);
        check("rst.issued", issued_count, 0);

        // Random traffic against a queue model of the expected issue order.
        do_reset();
        issues.delete(); expq.delete();
        prev_inst = instruction; am_phase = 0; exp_lf = 1'b0; auto_ack = 1'b1;
        for (int c = 0; c < 400; c++) begin
            run          = ($urandom_range(0, 9) != 0);
            s_inst_valid = 1'($urandom_range(0, 1));
            s_inst       = rand_inst();
            if (s_inst_valid && (queue_count < 4'(DEPTH)) && s_inst[67:64] != 4'h0)
                expq.push_back(s_inst);
            tick();
            check("rnd.count_bound", queue_count <= 4'(DEPTH), 1'b1);
        end
        s_inst_valid = 1'b0; run = 1'b1;
        drained = 1'b0;
        for (int k = 0; k < 3000 && !drained; k++) begin
            tick();
            if (queue_count == 4'd0 && !busy && am_phase == 0) drained = 1'b1;
        end
        check("rnd.drained", drained, 1'b1);
        check("rnd.issued_count", issued_count, 16'(expq.size()));
        check("rnd.issue_total", issues.size(), expq.size());
        for (int i = 0; i < expq.size() && i < issues.size(); i++)
            check($sformatf("rnd.order%0d", i), issues[i], expq[i]);
        check("rnd.last_flag", last_flag, exp_lf);
        check("rnd.error", error, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
